soc_addr_router: RTL
====================

SOC_ADDR_ROUTER -- requirements
Module: soc_addr_router

Interface
REQ-001 SHALL have parameter NR_RULES, default 11, number of address rules/targets (1..16).
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, request address width.
REQ-003 SHALL have parameter RULE_BASE, default the SoC map {DRAM 0x8000_0000, ECDSA 0x6000_0000, GPIO 0x4000_0000, Ethernet 0x3000_0000, SPI 0x2000_0000, Timer 0x1800_0000, UART 0x1000_0000, PLIC 0x0C00_0000, CLINT 0x0200_0000, ROM 0x0001_0000, Debug 0x0}, reset base per rule index 0..10.
REQ-004 SHALL have parameter RULE_LEN, default {0x4000_0000, 0x10000, 0x1000, 0x10000, 0x800000, 0x1000, 0x1000, 0x3FF_FFFF, 0xC0000, 0x10000, 0x1000}, reset length per rule.
REQ-005 SHALL derive localparam IDX_W = max(1, clog2(NR_RULES)).
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_ni  in  1  asynchronous active-low reset.
REQ-008 req_valid_i  in  1  request valid.
REQ-009 req_ready_o  out  1  request accepted when valid&ready.
REQ-010 req_addr_i  in  ADDR_WIDTH  request address.
REQ-011 out_valid_o  out  1  decoded result valid.
REQ-012 out_ready_i  in  1  consumer ready.
REQ-013 out_addr_o  out  ADDR_WIDTH  registered request address.
REQ-014 out_idx_o  out  IDX_W  matched rule index.
REQ-015 out_err_o  out  1  no rule matched (decode error).
REQ-016 cfg_we_i  in  1  config write strobe.
REQ-017 cfg_idx_i  in  IDX_W  rule to write.
REQ-018 cfg_field_i  in  1  0 = base, 1 = length.
REQ-019 cfg_wdata_i  in  ADDR_WIDTH  write data.
REQ-020 cfg_lock_i  in  1  sets sticky lock.
REQ-021 cfg_err_o  out  1  one-cycle pulse, write rejected.
REQ-022 locked_o  out  1  lock state.
REQ-023 err_cnt_o  out  16  decode-error count.

Function
REQ-024 Rule i SHALL match when addr >= base[i] and (addr - base[i]) < len[i], unsigned ADDR_WIDTH math; len 0 disables the rule; no overflow at top of address space.
REQ-025 On multiple matches the lowest index SHALL win; no match SHALL give out_err_o=1, out_idx_o=0.
REQ-026 Decode SHALL use rule values held at the start of the accepting cycle; a same-cycle config write affects only later requests.
REQ-027 One-entry output register: req_ready_o = !out_valid_o | out_ready_i; latency exactly 1 cycle from acceptance to out_valid_o.
REQ-028 out_valid_o SHALL stay high with out_addr/idx/err stable until out_ready_i; accept and drain in the same cycle SHALL load the new result with no bubble.
REQ-029 out_valid_o SHALL fall the cycle after drain when no new request is accepted.
REQ-030 Config write SHALL update the selected field next edge when not locked and cfg_idx_i < NR_RULES; otherwise no update and cfg_err_o=1 for one cycle.
REQ-031 cfg_lock_i SHALL set locked_o next edge; only reset clears it; a write and lock in the same cycle SHALL apply the write, then lock.
REQ-032 err_cnt_o SHALL increment by 1 for each accepted request that decodes to error, saturating at 0xFFFF.

Reset
REQ-033 On rst_ni low, asynchronously: out_valid_o=0, out_addr_o=0, out_idx_o=0, out_err_o=0, cfg_err_o=0, locked_o=0, err_cnt_o=0, rules = RULE_BASE/RULE_LEN; req_ready_o=1.
REQ-034 Reset mid-transfer SHALL discard the held result; the first request after deassertion SHALL decode with the default map.

Verification
REQ-035 Defaults, out_ready_i=1: addr 0x6000_0010 -> next cycle idx 1, err 0; 0x8000_0000 -> idx 0; 0xBFFF_FFFF -> idx 0; 0xC000_0000 -> err 1, idx 0, err_cnt_o 1.
REQ-036 Backpressure: out_ready_i=0, two back-to-back requests -> first held stable, req_ready_o=0; release -> second appears next cycle, no loss or duplication.
REQ-037 Overlap: write rule 2 base 0x6000_0000, len 0x100 -> 0x6000_0040 yields idx 1 (lower index wins); set rule 1 len 0 -> yields idx 2.
REQ-038 Lock: cfg_lock_i pulse, then write rule 0 base 0x0 -> cfg_err_o pulse, 0x8000_0000 still idx 0; write with cfg_idx_i 12 unlocked -> cfg_err_o pulse.
REQ-039 Saturation: 65537 unmapped requests -> err_cnt_o 0xFFFF.
REQ-040 Async reset asserted while out_valid_o=1 and out_ready_i=0 -> out_valid_o 0 immediately, locked_o 0, defaults restored.

Source files
------------

// File: rtl/soc_addr_router.sv
// soc_addr_router: decodes a request address against a programmable rule table
// (base/length per target) and returns the matching rule index through a
// one-entry output register with valid/ready handshaking.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   req_valid_i/req_ready_o       request handshake, req_addr_i request address
//   out_valid_o/out_ready_i       result handshake
//   out_addr_o/out_idx_o/out_err_o registered address, matched index, no-match flag
//   cfg_we_i/cfg_idx_i/cfg_field_i/cfg_wdata_i  rule write (field 0 base, 1 length)
//   cfg_lock_i/locked_o           sticky write lock (cleared only by reset)
//   cfg_err_o                     one-cycle pulse on a rejected write
//   err_cnt_o                     saturating count of accepted requests with no match
module soc_addr_router #(
  parameter int unsigned NR_RULES = 11,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RULE_BASE [NR_RULES] = '{
    ADDR_WIDTH'(32'h8000_0000), ADDR_WIDTH'(32'h6000_0000), ADDR_WIDTH'(32'h4000_0000),
    ADDR_WIDTH'(32'h3000_0000), ADDR_WIDTH'(32'h2000_0000), ADDR_WIDTH'(32'h1800_0000),
    ADDR_WIDTH'(32'h1000_0000), ADDR_WIDTH'(32'h0C00_0000), ADDR_WIDTH'(32'h0200_0000),
    ADDR_WIDTH'(32'h0001_0000), ADDR_WIDTH'(32'h0000_0000)},
  parameter logic [ADDR_WIDTH-1:0] RULE_LEN [NR_RULES] = '{
    ADDR_WIDTH'(32'h4000_0000), ADDR_WIDTH'(32'h0001_0000), ADDR_WIDTH'(32'h0000_1000),
    ADDR_WIDTH'(32'h0001_0000), ADDR_WIDTH'(32'h0080_0000), ADDR_WIDTH'(32'h0000_1000),
    ADDR_WIDTH'(32'h0000_1000), ADDR_WIDTH'(32'h03FF_FFFF), ADDR_WIDTH'(32'h000C_0000),
    ADDR_WIDTH'(32'h0001_0000), ADDR_WIDTH'(32'h0000_1000)},
  localparam int unsigned IDX_W = (NR_RULES > 1) ? $clog2(NR_RULES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [ADDR_WIDTH-1:0] out_addr_o,
  output logic [IDX_W-1:0]      out_idx_o,
  output logic                  out_err_o,
  input  logic                  cfg_we_i,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  logic                  cfg_field_i,
  input  logic [ADDR_WIDTH-1:0] cfg_wdata_i,
  input  logic                  cfg_lock_i,
  output logic                  cfg_err_o,
  output logic                  locked_o,
  output logic [15:0]           err_cnt_o
);

  logic [ADDR_WIDTH-1:0] base_q [NR_RULES];
  logic [ADDR_WIDTH-1:0] base_d [NR_RULES];
  logic [ADDR_WIDTH-1:0] len_q  [NR_RULES];
  logic [ADDR_WIDTH-1:0] len_d  [NR_RULES];

  logic                  out_valid_q, out_valid_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [IDX_W-1:0]      out_idx_q, out_idx_d;
  logic                  out_err_q, out_err_d;
  logic                  cfg_err_q, cfg_err_d;
  logic                  locked_q, locked_d;
  logic [15:0]           err_cnt_q, err_cnt_d;

  logic             accept;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             cfg_ok;

  assign req_ready_o = !out_valid_q || out_ready_i;
  assign accept      = req_valid_i && req_ready_o;

  // Scan from the top index down so the lowest matching index is the one left.
  // Offset compare (addr - base < len) avoids base + len wrapping at the top.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NR_RULES) - 1; i >= 0; i--) begin
      if ((req_addr_i >= base_q[i]) && ((req_addr_i - base_q[i]) < len_q[i])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Write checks the lock state held before this edge, so write+lock applies the write.
  assign cfg_ok = cfg_we_i && !locked_q && (32'(cfg_idx_i) < NR_RULES);

  always_comb begin
    base_d    = base_q;
    len_d     = len_q;
    cfg_err_d = cfg_we_i && !cfg_ok;
    locked_d  = locked_q || cfg_lock_i;
    for (int i = 0; i < int'(NR_RULES); i++) begin
      if (cfg_ok && (cfg_idx_i == IDX_W'(i))) begin
        if (cfg_field_i) len_d[i]  = cfg_wdata_i;
        else             base_d[i] = cfg_wdata_i;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_idx_d   = out_idx_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_addr_d  = req_addr_i;
      out_idx_d   = hit ? hit_idx : '0;
      out_err_d   = !hit;
      if (!hit && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NR_RULES); i++) begin
        base_q[i] <= RULE_BASE[i];
        len_q[i]  <= RULE_LEN[i];
      end
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_idx_q   <= '0;
      out_err_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      base_q      <= base_d;
      len_q       <= len_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_idx_q   <= out_idx_d;
      out_err_q   <= out_err_d;
      cfg_err_q   <= cfg_err_d;
      locked_q    <= locked_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_addr_o  = out_addr_q;
  assign out_idx_o   = out_idx_q;
  assign out_err_o   = out_err_q;
  assign cfg_err_o   = cfg_err_q;
  assign locked_o    = locked_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
